// File: rtl/read_2_top.sv
// read_2_top: 32x32 RAM with a small controller that copies word 2 into word 3
// after reset. The RAM also has a backdoor debug port for writes and reads.
`default_nettype none

module ram2 (
  input  logic        clk,
  input  logic [4:0]  raddr0_i,
  output logic [31:0] rdata0_o,
  input  logic [4:0]  raddr1_i,
  output logic [31:0] rdata1_o,
  input  logic [4:0]  dbg_raddr_i,
  output logic [31:0] dbg_rdata_o,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        wen_i,
  input  logic [4:0]  dbg_waddr_i,
  input  logic [31:0] dbg_wdata_i,
  input  logic        dbg_wen_i
);
  logic [31:0] mem_q [32];

  // No reset on the array. When both ports hit the same address, the debug
  // port is the later assignment and therefore wins.
  always_ff @(posedge clk) begin
    if (wen_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (dbg_wen_i) begin
      mem_q[dbg_waddr_i] <= dbg_wdata_i;
    end
  end

  assign rdata0_o    = mem_q[raddr0_i];
  assign rdata1_o    = mem_q[raddr1_i];
  assign dbg_rdata_o = mem_q[dbg_raddr_i];
endmodule

module read_2 (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic [31:0] rdata_0_i,
  output logic [4:0]  raddr_0_o,
  output logic [4:0]  waddr_0_o,
  output logic [31:0] wdata_0_o,
  output logic        wen_0_o,
  output logic        valid_o
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    raddr_0_o = 5'd0;
    waddr_0_o = 5'd0;
    wdata_0_o = 32'd0;
    wen_0_o   = 1'b0;
    valid_o   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = READ;
      end
      READ: begin
        raddr_0_o = 5'd2;
        data_d    = rdata_0_i;
        state_d   = WRITE;
      end
      WRITE: begin
        waddr_0_o = 5'd3;
        wdata_0_o = data_q;
        wen_0_o   = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
endmodule

module read_2_top (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  debug_write_addr,
  input  logic [31:0] debug_write_data,
  input  logic        debug_write_en,
  input  logic [4:0]  debug_addr,
  output logic [31:0] debug_data,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  output logic        valid
);
  logic [4:0]  raddr_0;
  logic [31:0] rdata_0;
  logic [4:0]  waddr_0;
  logic [31:0] wdata_0;
  logic        wen_0;

  ram2 u_ram (
    .clk         (clk),
    .raddr0_i    (raddr_0),
    .rdata0_o    (rdata_0),
    .raddr1_i    (raddr1),
    .rdata1_o    (rdata1),
    .dbg_raddr_i (debug_addr),
    .dbg_rdata_o (debug_data),
    .waddr_i     (waddr_0),
    .wdata_i     (wdata_0),
    .wen_i       (wen_0),
    .dbg_waddr_i (debug_write_addr),
    .dbg_wdata_i (debug_write_data),
    .dbg_wen_i   (debug_write_en)
  );

  read_2 u_ctrl (
    .clk       (clk),
    .rst_n_i   (rst),
    .rdata_0_i (rdata_0),
    .raddr_0_o (raddr_0),
    .waddr_0_o (waddr_0),
    .wdata_0_o (wdata_0),
    .wen_0_o   (wen_0),
    .valid_o   (valid)
  );
endmodule

`default_nettype wire

// File: tb/tb_read_2_top.sv
// Directed self-checking bench for read_2_top: copy latency, reset abort,
// write-port collision and backdoor accesses.
`default_nettype none

module tb_read_2_top;
  logic        clk;
  logic        rst;
  logic [4:0]  debug_write_addr;
  logic [31:0] debug_write_data;
  logic        debug_write_en;
  logic [4:0]  debug_addr;
  logic [31:0] debug_data;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        valid;

  int n_vec;
  int n_bad;

  read_2_top dut (
    .clk              (clk),
    .rst              (rst),
    .debug_write_addr (debug_write_addr),
    .debug_write_data (debug_write_data),
    .debug_write_en   (debug_write_en),
    .debug_addr       (debug_addr),
    .debug_data       (debug_data),
    .raddr1           (raddr1),
    .rdata1           (rdata1),
    .valid            (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [4:0] a, input logic [31:0] exp);
    debug_addr = a;
    #1;
    chk(tag, debug_data, exp);
  endtask

  task automatic chk_valid(input string tag, input logic exp);
    chk(tag, {31'd0, valid}, {31'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
    debug_write_addr = a;
    debug_write_data = d;
    debug_write_en   = 1'b1;
    step();
    debug_write_en   = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    debug_write_addr = 5'd0;
    debug_write_data = 32'd0;
    debug_write_en   = 1'b0;
    debug_addr       = 5'd0;
    raddr1           = 5'd0;
    repeat (2) @(negedge clk);

    // Basic copy with per-edge latency checks
    dbg_wr(5'd2, 32'd34);
    dbg_wr(5'd3, 32'd0);
    chk_valid("reset_valid", 1'b0);
    chk_word("reset_w2_loaded", 5'd2, 32'd34);
    rst = 1'b1;
    step();
    chk_valid("edge1_valid", 1'b0);
    chk_word("edge1_w3", 5'd3, 32'd0);
    step();
    chk_valid("edge2_valid", 1'b0);
    chk_word("edge2_w3", 5'd3, 32'd0);
    step();
    chk_valid("edge3_valid", 1'b1);
    chk_word("edge3_w3", 5'd3, 32'd34);
    repeat (3) step();
    chk_valid("edge6_valid", 1'b1);
    chk_word("edge6_w3", 5'd3, 32'd34);

    // Asynchronous reset drops valid without a clock edge
    rst = 1'b0;
    #1;
    chk_valid("async_rst_valid", 1'b0);

    // All-ones transfer
    dbg_wr(5'd2, 32'hFFFF_FFFF);
    dbg_wr(5'd3, 32'd0);
    rst = 1'b1;
    repeat (4) step();
    chk_word("ones_w3", 5'd3, 32'hFFFF_FFFF);
    chk_word("ones_w2", 5'd2, 32'hFFFF_FFFF);
    raddr1 = 5'd2;
    #1;
    chk("ones_rdata1", rdata1, 32'hFFFF_FFFF);
    chk_valid("ones_valid", 1'b1);

    // Reset during WRITE aborts the copy, then restarts with new data
    rst = 1'b0;
    dbg_wr(5'd2, 32'd100);
    dbg_wr(5'd3, 32'd0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk_valid("abort_valid", 1'b0);
    step();
    chk_word("abort_w3_untouched", 5'd3, 32'd0);
    dbg_wr(5'd2, 32'd7);
    rst = 1'b1;
    step();
    step();
    chk_valid("restart_edge2_valid", 1'b0);
    chk_word("restart_edge2_w3", 5'd3, 32'd0);
    step();
    chk_valid("restart_valid", 1'b1);
    chk_word("restart_w3", 5'd3, 32'd7);

    // Same-address collision: debug write wins
    rst = 1'b0;
    dbg_wr(5'd2, 32'd55);
    dbg_wr(5'd3, 32'd0);
    rst = 1'b1;
    step();
    step();
    debug_write_addr = 5'd3;
    debug_write_data = 32'd99;
    debug_write_en   = 1'b1;
    step();
    debug_write_en   = 1'b0;
    chk_word("collide_w3", 5'd3, 32'd99);
    chk_valid("collide_valid", 1'b1);

    // Different-address simultaneous writes both land
    rst = 1'b0;
    dbg_wr(5'd2, 32'd56);
    dbg_wr(5'd3, 32'd0);
    dbg_wr(5'd4, 32'd0);
    rst = 1'b1;
    step();
    step();
    debug_write_addr = 5'd4;
    debug_write_data = 32'd11;
    debug_write_en   = 1'b1;
    step();
    debug_write_en   = 1'b0;
    chk_word("dual_w3", 5'd3, 32'd56);
    chk_word("dual_w4", 5'd4, 32'd11);

    // Idle in DONE, later edits to word 2 are not copied
    repeat (10) step();
    chk_valid("done_hold_valid", 1'b1);
    dbg_wr(5'd2, 32'd5);
    chk_word("done_w2_new", 5'd2, 32'd5);
    chk_word("done_w3_kept", 5'd3, 32'd56);
    chk_valid("done_final_valid", 1'b1);
    raddr1 = 5'd3;
    #1;
    chk("done_rdata1", rdata1, 32'd56);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/read_2_top.md
READ_2_TOP -- requirements
Module: read_2_top

Interface
REQ-001 The module SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all sequential logic.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = in reset.
REQ-004 debug_write_addr  input  5  backdoor write address into the RAM.
REQ-005 debug_write_data  input  32  backdoor write data.
REQ-006 debug_write_en  input  1  backdoor write strobe, sampled on rising clk.
REQ-007 debug_addr  input  5  backdoor read address.
REQ-008 debug_data  output  32  combinational RAM contents at debug_addr.
REQ-009 raddr1  input  5  external second read-port address.
REQ-010 rdata1  output  32  combinational RAM contents at raddr1.
REQ-011 valid  output  1  high once the copy program has completed.

Function
REQ-012 Contains two submodules: ram2, a 32-entry x 32-bit RAM, and read_2, a controller that copies RAM word 2 into RAM word 3.
REQ-013 RAM: read ports rdata0/raddr0 (owned by the controller), rdata1/raddr1, and debug_data/debug_addr are all asynchronous (combinational) reads.
REQ-014 RAM: one synchronous write port (waddr, wdata, wen) driven by the controller, written on rising clk when wen=1.
REQ-015 RAM: debug write port written on rising clk when debug_write_en=1.
REQ-016 RAM: if both write ports target the same address in one cycle, debug data wins; different addresses are both written.
REQ-017 RAM: contents are NOT cleared or blocked by reset; debug writes take effect while rst=0.
REQ-018 RAM: after a write on edge N, all read ports return the new value from edge N onward; no read-during-write bypass.
REQ-019 Controller states: IDLE, READ, WRITE, DONE; state register 2 bits.
REQ-020 IDLE: entered on reset; wen_0=0, valid=0; moves to READ on the first rising clk with rst=1.
REQ-021 READ: drives raddr_0=2; on rising clk latches rdata_0 into a 32-bit data register and moves to WRITE.
REQ-022 WRITE: drives waddr_0=3, wdata_0=data register, wen_0=1 for exactly one cycle; moves to DONE.
REQ-023 DONE: wen_0=0, valid=1; stays in DONE until reset.
REQ-024 Outside WRITE, wen_0=0; waddr_0, wdata_0, raddr_0 are don't-care but SHALL be driven (no X): 0 outside their active state.
REQ-025 Latency: valid rises on the 3rd rising clk after rst deasserts; word 3 is updated on the 3rd rising clk.
REQ-026 The copy is a full 32-bit transfer; no arithmetic, no width change.
REQ-027 Reset asserted mid-operation aborts the copy immediately; on release the program restarts from IDLE and re-copies.

Reset
REQ-028 On rst=0: state=IDLE, valid=0, wen_0=0, data register=0, asynchronously and independent of clk.
REQ-029 RAM array has no reset value; verification SHALL initialise it through the debug write port.

Verification
REQ-030 Hold rst=0, debug write 34 to address 2, release rst, run 6 clocks, debug_addr=3 -> debug_data=34, valid=1.
REQ-031 Same as REQ-030 but sample each cycle -> valid=0 after 1st and 2nd edge, 1 from 3rd edge; word 3 unchanged before 3rd edge.
REQ-032 Write 0xFFFFFFFF to address 2, run -> debug_data at 3 = 0xFFFFFFFF; word 2 still 0xFFFFFFFF; raddr1=2 gives rdata1=0xFFFFFFFF.
REQ-033 Assert rst during WRITE, change word 2 to 7 via debug, release -> valid drops to 0 immediately, later rises; word 3 = 7.
REQ-034 Debug write to address 3 (value 99) on the same edge as the controller write -> word 3 = 99.
REQ-035 Leave controller in DONE for 10 clocks, debug write 5 to address 2 -> word 3 unchanged, valid stays 1.
